// File: rtl/alu_exec.sv
// Handshaked ALU: single-cycle logic/arith ops, bit-serial shifts and a shift-add multiplier.
// Results are held in DONE until the consumer takes them.
module alu_exec #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  // Counter must hold both WIDTH (multiply) and 15 (largest shift amount).
  localparam int CW = ($clog2(WIDTH + 1) > 4) ? $clog2(WIDTH + 1) : 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [CW-1:0] count_t;

  state_t           state_reg,  state_next;
  logic [2:0]       op_reg,     op_next;
  logic [WIDTH-1:0] acc_reg,    acc_next;
  logic [WIDTH-1:0] opa_reg,    opa_next;
  logic [WIDTH-1:0] opb_reg,    opb_next;
  count_t           count_reg,  count_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg,   zero_next;

  logic [WIDTH-1:0] step_val;
  logic             iterative;

  // Shifts by zero fall through to the default arm and return a unchanged.
  function automatic logic [WIDTH-1:0] quick_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = x;
    case (op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_SLT: begin
        r    = '0;
        r[0] = ($signed(x) < $signed(y));
      end
      default: r = x;
    endcase
    return r;
  endfunction

  always_comb begin
    iterative = (aluop == OP_MUL) ||
                (((aluop == OP_SHL) || (aluop == OP_SHR)) && (b[3:0] != 4'd0));
  end

  // One bit of work per RUN cycle, selected by the latched opcode.
  always_comb begin
    step_val = acc_reg;
    case (op_reg)
      OP_SHL:  step_val = acc_reg << 1;
      OP_SHR:  step_val = acc_reg >> 1;
      OP_MUL:  step_val = acc_reg + (opb_reg[0] ? opa_reg : '0);
      default: step_val = acc_reg;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    acc_next    = acc_reg;
    opa_next    = opa_reg;
    opb_next    = opb_reg;
    count_next  = count_reg;
    result_next = result_reg;
    zero_next   = zero_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          op_next = aluop;
          if (iterative) begin
            state_next = RUN;
            if (aluop == OP_MUL) begin
              acc_next   = '0;
              opa_next   = a;
              opb_next   = b;
              count_next = count_t'(WIDTH);
            end else begin
              acc_next   = a;
              count_next = count_t'(b[3:0]);
            end
          end else begin
            state_next  = DONE;
            result_next = quick_op(aluop, a, b);
            zero_next   = (quick_op(aluop, a, b) == '0);
          end
        end
      end
      RUN: begin
        acc_next   = step_val;
        opa_next   = opa_reg << 1;
        opb_next   = opb_reg >> 1;
        count_next = count_reg - count_t'(1);
        if (count_reg == count_t'(1)) begin
          state_next  = DONE;
          result_next = step_val;
          zero_next   = (step_val == '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      acc_reg    <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      count_reg  <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      acc_reg    <= acc_next;
      opa_reg    <= opa_next;
      opb_reg    <= opb_next;
      count_reg  <= count_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign result    = result_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases plus random ops checked
// against an arithmetic reference model of results and handshake latency.
module tb_alu_exec;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       aluop = '0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic int ref_result(input int op, input int av, input int bv);
    longint p;
    case (op)
      0: return (av + bv) % 65536;
      1: return (av - bv + 65536) % 65536;
      2: return av & bv;
      3: return av | bv;
      4: return (to_signed(av) < to_signed(bv)) ? 1 : 0;
      5: return (av * (2 ** (bv % 16))) % 65536;
      6: return av / (2 ** (bv % 16));
      default: begin
        p = longint'(av) * longint'(bv);
        return int'(p % 65536);
      end
    endcase
  endfunction

  function automatic int ref_latency(input int op, input int bv);
    if (op == 7) return WIDTH + 1;
    if (op == 5 || op == 6) return (bv % 16) + 1;
    return 1;
  endfunction

  task automatic do_op(input int op, input int av, input int bv, input int stall,
                       input bit ready_early, input bit hold_valid, input string tag);
    int exp_r, exp_lat, lat;
    exp_r   = ref_result(op, av, bv);
    exp_lat = ref_latency(op, bv);
    @(negedge clk);
    in_valid  = 1'b1;
    aluop     = 3'(op);
    a         = 16'(av);
    b         = 16'(bv);
    out_ready = ready_early;
    chk({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    if (!hold_valid) in_valid = 1'b0;
    aluop = 3'($urandom);
    a     = 16'($urandom);
    b     = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":result"}, 32'(result), 32'(exp_r));
    chk({tag, ":zero"}, 32'(zero), 32'(exp_r == 0));
    chk({tag, ":busy_done"}, 32'(busy), 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, ":stall_result"}, 32'(result), 32'(exp_r));
      chk({tag, ":stall_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, ":stall_out_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ":handoff_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ":handoff_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ":result_kept"}, 32'(result), 32'(exp_r));
    $display("op=%0d a=0x%04h b=0x%04h result=0x%04h exp=0x%04h lat=%0d exp_lat=%0d stall=%0d",
             op, av, bv, result, exp_r, lat, exp_lat, stall);
  endtask

  initial begin
    int op, av, bv, st;
    bit seen;
    // Reset with no clock edge yet
    #1 rst = 1'b1;
    #1;
    chk("rst:out_valid", 32'(out_valid), 32'd0);
    chk("rst:result", 32'(result), 32'd0);
    chk("rst:zero", 32'(zero), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    do_op(0, 16'h7FFF, 16'h0001, 0, 1'b1, 1'b0, "add");
    do_op(1, 5, 5, 0, 1'b1, 1'b0, "sub_zero");
    do_op(5, 16'h0003, 4, 3, 1'b0, 1'b0, "shl_stall");
    do_op(7, 16'h0123, 16'h0100, 0, 1'b1, 1'b0, "mul");
    do_op(4, 16'hFFFF, 16'h0001, 0, 1'b1, 1'b0, "slt");
    do_op(6, 16'h8000, 16'h000F, 1, 1'b0, 1'b0, "shr15");
    do_op(5, 16'hA5A5, 16'h0010, 0, 1'b1, 1'b0, "shl_n0");
    do_op(7, 16'h1234, 16'h00FF, 0, 1'b1, 1'b1, "mul_hold_valid");
    do_op(6, 16'hF00F, 16'h0003, 0, 1'b1, 1'b1, "shr_hold_valid");

    // Reset 8 cycles into a multiply abandons it
    @(negedge clk);
    in_valid = 1'b1; aluop = 3'd7; a = 16'h00FF; b = 16'h00FF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst:out_valid", 32'(out_valid), 32'd0);
    chk("midrst:busy", 32'(busy), 32'd0);
    chk("midrst:result", 32'(result), 32'd0);
    chk("midrst:in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (WIDTH + 4) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst:no_out_valid", 32'(seen), 32'd0);
    do_op(0, 2, 3, 0, 1'b1, 1'b0, "add_after_rst");

    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 7));
      av = int'($urandom_range(0, 65535));
      bv = int'($urandom_range(0, 65535));
      if (i % 5 == 0) bv = av;
      st = int'($urandom_range(0, 3));
      do_op(op, av, bv, st, (st == 0) ? 1'($urandom) : 1'b0, 1'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.

Interface
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  the producer offers an operation this cycle.
REQ-005 in_ready  output  1  the block can accept an operation; high only in IDLE.
REQ-006 aluop  input  3  operation code from ALU control, sampled at accept.
REQ-007 a  input  WIDTH  operand A, sampled at accept.
REQ-008 b  input  WIDTH  operand B, sampled at accept.
REQ-009 out_valid  output  1  result and zero are valid.
REQ-010 out_ready  input  1  the consumer takes the result this cycle.
REQ-011 result  output  WIDTH  registered operation result.
REQ-012 zero  output  1  registered flag, high when result equals 0.
REQ-013 busy  output  1  high in RUN and DONE.

Function
REQ-014 Accept SHALL occur on a rising edge where in_valid and in_ready are both high; operands and aluop are latched at accept, and later input changes are ignored.
REQ-015 The state machine SHALL have three states: IDLE, RUN and DONE; in_ready is high only in IDLE and out_valid is high only in DONE.
REQ-016 aluop decode SHALL be:
  - 000 ADD: a+b.
  - 001 SUB: a-b.
  - 010 AND.
  - 011 OR.
  - 100 SLT: 1 if signed a < signed b, else 0.
  - 101 SHL: logical left shift of a by b[3:0].
  - 110 SHR: logical right shift of a by b[3:0].
  - 111 MUL: low WIDTH bits of a*b.
REQ-017 ADD, SUB and MUL SHALL wrap modulo 2^WIDTH; no carry or overflow outputs.
REQ-018 Single-cycle ops (000-100) SHALL go IDLE->DONE at the edge after accept; out_valid is high one cycle after accept.
REQ-019 A shift with n=b[3:0] SHALL:
  - move one bit per cycle in RUN;
  - raise out_valid n+1 cycles after accept;
  - for n=0, take the single-cycle path and return a unchanged.
REQ-020 MUL SHALL be iterative shift-add, one multiplier bit per cycle, WIDTH cycles in RUN; out_valid is high WIDTH+1 cycles after accept.
REQ-021 In DONE, result and zero SHALL hold stable until an edge with out_ready high; that edge returns the block to IDLE, dropping out_valid and raising in_ready.
REQ-022 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE, so no new accept occurs in the same cycle as result handoff.
REQ-023 zero SHALL be registered together with result and be valid whenever out_valid is high.
REQ-024 result SHALL keep its last value after handoff until the next operation completes.

Reset
REQ-025 While rst is high, the block SHALL:
  - force state to IDLE;
  - set out_valid=0, result=0, zero=0, busy=0;
  - set in_ready=1 and clear the internal counter and operand registers.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abandon the operation with no out_valid pulse; the first accept is possible on the first edge after rst falls.

Verification
REQ-027 Reset: rst=1 with no clock edge -> out_valid=0, result=0, zero=0, busy=0, in_ready=1.
REQ-028 ADD then SUB, WIDTH=16, out_ready=1:
  - aluop=000, a=0x7FFF, b=0x0001 -> result=0x8000, zero=0, out_valid one cycle after accept.
  - aluop=001, a=5, b=5 -> result=0, zero=1.
REQ-029 SHL with consumer stall:
  - aluop=101, a=0x0003, b=4 -> out_valid 5 cycles after accept, result=0x0030.
  - hold out_ready=0 for 3 cycles -> result stable and in_ready=0 throughout.
  - raise out_ready -> IDLE on that edge.
REQ-030 MUL and SLT:
  - aluop=111, a=0x0123, b=0x0100 -> out_valid 17 cycles after accept, result=0x2300.
  - aluop=100, a=0xFFFF, b=0x0001 -> result=1.
REQ-031 Reset and ignored inputs:
  - rst pulsed 8 cycles into a MUL -> no out_valid; next ADD 2+3 returns 5.
  - in_valid held high during RUN -> no extra accept.
